cordic_iter_ctrl: RTL and testbench

Sequencer for the iterative rotation-mode CORDIC engine. Accepts a target angle on a start handshake and folds it into the convergence range. It then steps the x/y shift-add datapath through ITERATIONS micro-rotations, driving the load enable, shift index and rotation direction each cycle. It owns the angle accumulator (z register) and the arctangent ROM. The x/y registers and the shifters sit in the external datapath and are slaved to this block's outputs.

---
 rtl/cordic_iter_ctrl.sv | 159 +++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl
//   Sequencer for an iterative rotation-mode CORDIC engine. Accepts a target
//   angle on a start handshake and folds it into the convergence range
//   (|z| <= pi/2). It then steps the external x/y shift-add datapath through
//   ITERATIONS micro-rotations. This block owns the residual-angle (z)
//   register and the arctangent ROM.
//
// Ports
//   clk           clock, rising edge
//   rst_in        asynchronous active-high reset
//   start_in      start request, accepted only while ready_out=1
//   angle_in      signed binary angle (2^(WIDTH-1) = pi), sampled on accept
//   ready_out     high in IDLE
//   busy_out      high in LOAD, ITER and DONE
//   load_en_out   one-cycle pulse in LOAD; datapath loads x0/y0
//   quad_flip_out registered; datapath negates x0/y0 on load when set
//   iter_en_out   high during ITER; datapath performs a shift-add
//   shift_out     current iteration index (0 outside ITER)
//   dir_out       1 = counter-clockwise (z >= 0), 0 = clockwise (0 outside ITER)
//   z_out         residual angle, registered
//   done_out      one-cycle pulse in DONE; z_out is final in that cycle

module cordic_iter_ctrl #(
  parameter int unsigned  WIDTH      = 16,
  parameter int unsigned  ITERATIONS = 12,
  localparam int unsigned CntW       = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] angle_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             load_en_out,
  output logic             quad_flip_out,
  output logic             iter_en_out,
  output logic [CntW-1:0]  shift_out,
  output logic             dir_out,
  output logic [WIDTH-1:0] z_out,
  output logic             done_out
);

  localparam logic [CntW-1:0]  LastIter   = CntW'(ITERATIONS - 1);
  localparam logic [WIDTH-1:0] QuarterPos = WIDTH'(1) << (WIDTH - 2);
  localparam logic [WIDTH-1:0] QuarterNeg = -QuarterPos;

  // The ROM holds the exact 16-bit-angle values; other widths rescale them.
  // Narrower widths round the scaled value, wider widths only shift.
  localparam int unsigned ShUp   = (WIDTH >= 16) ? WIDTH - 16 : 0;
  localparam int unsigned ShDn   = (WIDTH < 16) ? 16 - WIDTH : 0;
  localparam logic [47:0] RndAdd = (48'd1 << ShDn) >> 1;

  function automatic logic [WIDTH-1:0] atan_rom(input logic [CntW-1:0] idx);
    logic [47:0] base;
    case (int'(idx))
      0:       base = 48'd8192;
      1:       base = 48'd4836;
      2:       base = 48'd2555;
      3:       base = 48'd1297;
      4:       base = 48'd651;
      5:       base = 48'd326;
      6:       base = 48'd163;
      7:       base = 48'd81;
      8:       base = 48'd41;
      9:       base = 48'd20;
      10:      base = 48'd10;
      11:      base = 48'd5;
      12:      base = 48'd3;
      13:      base = 48'd1;
      14:      base = 48'd1;
      default: base = 48'd0;
    endcase
    return WIDTH'(((base + RndAdd) >> ShDn) << ShUp);
  endfunction

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [CntW-1:0]  r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_z, w_z_next;
  logic             r_quad_flip, w_quad_flip_next;
  logic             w_fold;
  logic [WIDTH-1:0] w_atan;

  assign z_out         = r_z;
  assign quad_flip_out = r_quad_flip;

  // Angles strictly beyond +-pi/2 are rotated by pi; the datapath negates x0/y0
  // to compensate. Adding pi modulo 2^WIDTH is just an MSB flip.
  assign w_fold = ($signed(angle_in) > $signed(QuarterPos)) ||
                  ($signed(angle_in) < $signed(QuarterNeg));
  assign w_atan = atan_rom(r_cnt);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_z         <= '0;
      r_quad_flip <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_z         <= w_z_next;
      r_quad_flip <= w_quad_flip_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = '0;
    w_z_next         = r_z;
    w_quad_flip_next = r_quad_flip;
    ready_out        = 1'b0;
    busy_out         = 1'b0;
    load_en_out      = 1'b0;
    iter_en_out      = 1'b0;
    shift_out        = '0;
    dir_out          = 1'b0;
    done_out         = 1'b0;

    unique case (r_state)
      StIdle: begin
        ready_out = 1'b1;
        if (start_in) begin
          w_state_next     = StLoad;
          w_quad_flip_next = w_fold;
          w_z_next         = w_fold ? {~angle_in[WIDTH-1], angle_in[WIDTH-2:0]} : angle_in;
        end
      end
      StLoad: begin
        busy_out     = 1'b1;
        load_en_out  = 1'b1;
        w_state_next = StIter;
      end
      StIter: begin
        busy_out    = 1'b1;
        iter_en_out = 1'b1;
        shift_out   = r_cnt;
        dir_out     = ~r_z[WIDTH-1];
        // Rotate towards zero residual; two's-complement wrap is intended.
        w_z_next    = dir_out ? (r_z - w_atan) : (r_z + w_atan);
        if (r_cnt == LastIter) begin
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StDone: begin
        busy_out     = 1'b1;
        done_out     = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed and randomized bench for cordic_iter_ctrl at default parameters
// (WIDTH=16, ITERATIONS=12).

module tb_cordic_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [15:0] angle_in;
  logic        ready_out;
  logic        busy_out;
  logic        load_en_out;
  logic        quad_flip_out;
  logic        iter_en_out;
  logic [3:0]  shift_out;
  logic        dir_out;
  logic [15:0] z_out;
  logic        done_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int Atan [12] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5};

  cordic_iter_ctrl dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .angle_in      (angle_in),
    .ready_out     (ready_out),
    .busy_out      (busy_out),
    .load_en_out   (load_en_out),
    .quad_flip_out (quad_flip_out),
    .iter_en_out   (iter_en_out),
    .shift_out     (shift_out),
    .dir_out       (dir_out),
    .z_out         (z_out),
    .done_out      (done_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_z(input logic [15:0] a, output logic f);
    logic [15:0] z;
    f = ($signed(a) > 16'sd16384) || ($signed(a) < -16'sd16384);
    z = f ? (a + 16'h8000) : a;
    for (int i = 0; i < 12; i++) z = z[15] ? (z + 16'(Atan[i])) : (z - 16'(Atan[i]));
    return z;
  endfunction

  task automatic wait_idle();
    int g = 0;
    while (!ready_out && g < 50) begin
      @(posedge clk); #1; g++;
    end
  endtask

  // Runs one operation from IDLE and captures what the DUT did, up to the DONE cycle.
  task automatic run_op(input logic [15:0] ang, output logic [11:0] dirs, output int n_iter,
                        output int lat, output logic shift_ok, output logic flip,
                        output logic [15:0] z_load, output logic [15:0] z_fin, output int n_load);
    wait_idle();
    start_in = 1'b1; angle_in = ang;
    @(posedge clk); #1;
    start_in = 1'b0;
    lat = 1; dirs = '0; n_iter = 0; shift_ok = 1'b1;
    flip = quad_flip_out; z_load = z_out; n_load = load_en_out ? 1 : 0;
    while (!done_out && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (iter_en_out) begin
        if (shift_out !== 4'(n_iter)) shift_ok = 1'b0;
        if (n_iter < 12) dirs[n_iter] = dir_out;
        n_iter++;
      end
      if (load_en_out) n_load++;
    end
    z_fin = z_out;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b0; angle_in = '0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({ready_out, busy_out, load_en_out, iter_en_out, done_out, quad_flip_out, dir_out}
        !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 1000000", {ready_out, busy_out, load_en_out,
               iter_en_out, done_out, quad_flip_out, dir_out});
    end
    n_checks++;
    if (z_out !== 16'h0000) begin n_fail++; $display("FAIL reset_z: got %h want 0000", z_out); end
    n_checks++;
    if (shift_out !== 4'd0) begin n_fail++; $display("FAIL reset_shift: got %0d want 0", shift_out); end
    rst_in = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_zero_angle();
    logic [11:0] dirs; int n_iter, lat, n_load; logic shift_ok, flip; logic [15:0] zl, zf;
    run_op(16'd0, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (lat !== 14) begin n_fail++; $display("FAIL zero_latency: got %0d want 14", lat); end
    n_checks++;
    if (dirs !== 12'b0000_1101_0001) begin n_fail++; $display("FAIL zero_dirs: got %b want 000011010001", dirs); end
    n_checks++;
    if (n_iter !== 12) begin n_fail++; $display("FAIL zero_iter_count: got %0d want 12", n_iter); end
    n_checks++;
    if (shift_ok !== 1'b1) begin n_fail++; $display("FAIL zero_shift_seq: got %b want 1", shift_ok); end
    n_checks++;
    if (flip !== 1'b0 || zl !== 16'h0000) begin n_fail++; $display("FAIL zero_load: got flip=%b z=%h want flip=0 z=0000", flip, zl); end
    n_checks++;
    if (n_load !== 1) begin n_fail++; $display("FAIL zero_load_pulses: got %0d want 1", n_load); end
    n_checks++;
    if (zf !== 16'd3) begin n_fail++; $display("FAIL zero_final_z: got %0d want 3", $signed(zf)); end
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (z_out !== 16'd3 || quad_flip_out !== 1'b0 || ready_out !== 1'b1 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_hold: got z=%0d flip=%b ready=%b busy=%b want z=3 flip=0 ready=1 busy=0",
               $signed(z_out), quad_flip_out, ready_out, busy_out);
    end
  endtask

  task automatic test_pi4();
    logic [11:0] dirs; int n_iter, lat, n_load; logic shift_ok, flip; logic [15:0] zl, zf;
    run_op(16'd8192, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (dirs !== 12'b1111_1000_0011) begin n_fail++; $display("FAIL pi4_dirs: got %b want 111110000011", dirs); end
    n_checks++;
    if (zf !== 16'hFFFF || flip !== 1'b0) begin n_fail++; $display("FAIL pi4_final: got z=%0d flip=%b want z=-1 flip=0", $signed(zf), flip); end
  endtask

  task automatic test_fold();
    logic [11:0] dirs; int n_iter, lat, n_load; logic shift_ok, flip; logic [15:0] zl, zf;
    run_op(16'd24576, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (flip !== 1'b1 || zl !== 16'hE000) begin n_fail++; $display("FAIL fold_24576_load: got flip=%b z=%h want flip=1 z=e000", flip, zl); end
    n_checks++;
    if (dirs !== 12'b1111_1000_0010 || zf !== 16'hFFFF) begin n_fail++; $display("FAIL fold_24576_run: got dirs=%b z=%0d want 111110000010 z=-1", dirs, $signed(zf)); end
    run_op(16'hE000, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (flip !== 1'b0 || dirs !== 12'b1111_1000_0010 || zf !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL fold_m8192_run: got flip=%b dirs=%b z=%0d want 0 111110000010 -1", flip, dirs, $signed(zf));
    end
    run_op(16'h4000, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (flip !== 1'b0 || zl !== 16'h4000) begin n_fail++; $display("FAIL fold_p16384: got flip=%b z=%h want flip=0 z=4000", flip, zl); end
    run_op(16'hBFFF, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (flip !== 1'b1 || zl !== 16'h3FFF) begin n_fail++; $display("FAIL fold_m16385: got flip=%b z=%h want flip=1 z=3fff", flip, zl); end
    run_op(16'hC000, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (flip !== 1'b0 || zl !== 16'hC000) begin n_fail++; $display("FAIL fold_m16384: got flip=%b z=%h want flip=0 z=c000", flip, zl); end
    run_op(16'h8000, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
    n_checks++;
    if (flip !== 1'b1 || zl !== 16'h0000) begin n_fail++; $display("FAIL fold_mpi: got flip=%b z=%h want flip=1 z=0000", flip, zl); end
  endtask

  task automatic test_back_to_back();
    int lp [3]; int dp [3]; int nl = 0; int nd = 0;
    wait_idle();
    start_in = 1'b1; angle_in = 16'd0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (load_en_out) begin if (nl < 3) lp[nl] = c; nl++; end
      if (done_out) begin if (nd < 3) dp[nd] = c; nd++; end
    end
    start_in = 1'b0;
    n_checks++;
    if (nl !== 3 || nd !== 3) begin n_fail++; $display("FAIL b2b_counts: got loads=%0d dones=%0d want 3 3", nl, nd); end
    else begin
      n_checks++;
      if (lp[0] !== 1 || lp[1] !== 16 || lp[2] !== 31) begin
        n_fail++; $display("FAIL b2b_load_cycles: got %0d %0d %0d want 1 16 31", lp[0], lp[1], lp[2]);
      end
      n_checks++;
      if (dp[0] !== 14 || dp[1] !== 29 || dp[2] !== 44) begin
        n_fail++; $display("FAIL b2b_done_cycles: got %0d %0d %0d want 14 29 44", dp[0], dp[1], dp[2]);
      end
    end
    wait_idle();
  endtask

  task automatic test_ignored_start();
    int nl = 0; int g = 0;
    wait_idle();
    start_in = 1'b1; angle_in = 16'd0;
    @(posedge clk); #1;
    start_in = 1'b0;
    if (load_en_out) nl++;
    repeat (4) begin @(posedge clk); #1; if (load_en_out) nl++; end
    start_in = 1'b1; angle_in = 16'h1234;
    @(posedge clk); #1;
    start_in = 1'b0; angle_in = 16'd0;
    if (load_en_out) nl++;
    while (!done_out && g < 30) begin @(posedge clk); #1; g++; if (load_en_out) nl++; end
    n_checks++;
    if (done_out !== 1'b1 || z_out !== 16'd3) begin n_fail++; $display("FAIL ign_iter_result: got done=%b z=%0d want done=1 z=3", done_out, $signed(z_out)); end
    start_in = 1'b1; angle_in = 16'h1234;
    @(posedge clk); #1;
    start_in = 1'b0;
    n_checks++;
    if (ready_out !== 1'b1 || load_en_out !== 1'b0) begin n_fail++; $display("FAIL ign_done_state: got ready=%b load=%b want 1 0", ready_out, load_en_out); end
    repeat (3) begin @(posedge clk); #1; if (load_en_out) nl++; end
    n_checks++;
    if (nl !== 1 || ready_out !== 1'b1 || z_out !== 16'd3) begin
      n_fail++; $display("FAIL ign_loads: got loads=%0d ready=%b z=%0d want 1 1 3", nl, ready_out, $signed(z_out));
    end
  endtask

  task automatic test_reset_mid_iter();
    int g = 0; int nd = 0;
    wait_idle();
    start_in = 1'b1; angle_in = 16'd24576;
    @(posedge clk); #1;
    start_in = 1'b0;
    while (!(iter_en_out && shift_out == 4'd5) && g < 20) begin @(posedge clk); #1; g++; end
    n_checks++;
    if (shift_out !== 4'd5 || quad_flip_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach: got shift=%0d flip=%b want 5 1", shift_out, quad_flip_out); end
    rst_in = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ready_out, busy_out, iter_en_out, done_out, quad_flip_out} !== 5'b10000 || z_out !== 16'h0000 || shift_out !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state: got rbidf=%b z=%h shift=%0d want 10000 0000 0",
               {ready_out, busy_out, iter_en_out, done_out, quad_flip_out}, z_out, shift_out);
    end
    rst_in = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done_out) nd++; end
    n_checks++;
    if (nd !== 0 || ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_no_done: got dones=%0d ready=%b want 0 1", nd, ready_out); end
  endtask

  task automatic test_sweep();
    logic [11:0] dirs; int n_iter, lat, n_load; logic shift_ok, flip; logic [15:0] zl, zf;
    logic [15:0] a, exp_z; logic exp_f;
    for (int k = 0; k < 16; k++) begin
      a = 16'($urandom);
      exp_z = model_z(a, exp_f);
      run_op(a, dirs, n_iter, lat, shift_ok, flip, zl, zf, n_load);
      n_checks++;
      if (n_iter !== 12 || shift_ok !== 1'b1 || lat !== 14) begin
        n_fail++; $display("FAIL sweep_seq a=%h: got iters=%0d shift_ok=%b lat=%0d want 12 1 14", a, n_iter, shift_ok, lat);
      end
      n_checks++;
      if (zf !== exp_z || flip !== exp_f) begin
        n_fail++; $display("FAIL sweep_result a=%h: got z=%0d flip=%b want z=%0d flip=%b", a, $signed(zf), flip, $signed(exp_z), exp_f);
      end
      n_checks++;
      if ($signed(zf) > 16'sd10 || $signed(zf) < -16'sd10) begin
        n_fail++; $display("FAIL sweep_converge a=%h: got z=%0d want |z|<=10", a, $signed(zf));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_angle();
    test_pi4();
    test_fold();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_iter();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
